wrapper_seq_ctrl: RTL and testbench
===================================

WRAPPER_SEQ_CTRL -- requirements
Module: wrapper_seq_ctrl

Interface
REQ-001 Parameter CNT_W, default 4, width of the item counter.
REQ-002 Parameter ITEMS, default 10, engine runs per job; legal range 1..2^CNT_W.
REQ-003 Parameter TO_W, default 8, width of the engine-timeout timer.
REQ-004 Parameter TIMEOUT, default 200, max WaitComp cycles; 0 disables timeout; legal range 0..2^TO_W-1.
REQ-005 Port clk, input, 1, sole clock; all state changes on its rising edge.
REQ-006 Port rst, input, 1, synchronous active-high reset.
REQ-007 Port start, input, 1, job request level from user.
REQ-008 Port abort, input, 1, cancel current job.
REQ-009 Port eng_done, input, 1, engine completion pulse or level.
REQ-010 Port fifo_full, input, 1, result FIFO cannot accept a write.
REQ-011 Port fifo_empty, input, 1, result FIFO holds no data.
REQ-012 Port read_sw, input, 1, user read switch, already synchronised.
REQ-013 Port eng_start, output, 1, one-cycle engine start pulse.
REQ-014 Port rd_req, output, 1, one-cycle FIFO read pulse.
REQ-015 Port done, output, 1, controller idle and ready.
REQ-016 Port busy, output, 1, job in progress (any state except Idle, Error).
REQ-017 Port err_timeout, output, 1, sticky engine-timeout flag.
REQ-018 Port item_idx, output, CNT_W, index of the current engine run.
REQ-019 Port ps, output, 4, current state code for debug.

Function
REQ-020 State codes SHALL be fixed: Idle=0, Init=1, WaitSpace=2, Issue=3, WaitComp=4, Write=5, Drain=6, ReadReq=7, WaitRel=8, Error=9; codes 10-15 SHALL go to Idle next cycle.
REQ-021 Outputs eng_start, rd_req, done, busy SHALL be Moore-decoded from ps only: done=1 in Idle; eng_start=1 in Issue; rd_req=1 in ReadReq.
REQ-022 Idle: start=1 -> Init; else stay.
REQ-023 Init: item_idx<=0, timer<=0, err_timeout<=0; stay while start=1; start=0 -> WaitSpace.
REQ-024 WaitSpace: fifo_full=0 -> Issue; else stay (no engine start while FIFO full).
REQ-025 Issue: timer<=0; unconditionally -> WaitComp; eng_start high exactly one cycle per run.
REQ-026 WaitComp: eng_done=1 -> Write (eng_done takes priority over timeout in same cycle); else timer increments; if TIMEOUT!=0 and timer==TIMEOUT-1 -> Error with err_timeout<=1.
REQ-027 Write: if item_idx==ITEMS-1 -> Drain, item_idx held; else item_idx<=item_idx+1 -> WaitSpace.
REQ-028 Drain: fifo_empty=1 -> Idle (priority); else read_sw=1 -> ReadReq; else stay.
REQ-029 ReadReq: unconditionally -> WaitRel; exactly one rd_req pulse per switch press.
REQ-030 WaitRel: read_sw=1 -> stay; read_sw=0 -> Drain.
REQ-031 Error: done=0, busy=0, err_timeout held 1; start=1 -> Init; else stay.
REQ-032 abort=1 in any state except Idle SHALL force Idle next cycle, overriding all other transitions; item_idx and err_timeout unchanged.
REQ-033 Arithmetic: item_idx and timer SHALL not wrap within a legal job; timer saturates at 2^TO_W-1 when TIMEOUT=0.
REQ-034 Total cycles start-release to Drain with zero-latency engine and FIFO never full: 4*ITEMS cycles.

Reset
REQ-035 rst=1 at a clock edge SHALL set ps=Idle, item_idx=0, timer=0, err_timeout=0, regardless of state or other inputs.
REQ-036 After reset: done=1, busy=0, eng_start=0, rd_req=0; rst mid-job SHALL discard the job with no further eng_start/rd_req pulses.

Verification
REQ-037 ITEMS=3, start 2 cycles then 0, eng_done 1 cycle after each eng_start, fifo_full=0 -> exactly 3 eng_start pulses, item_idx 0,1,2, ps reaches 6.
REQ-038 In Drain, fifo_empty=0, read_sw held high 5 cycles twice -> exactly 2 rd_req pulses; then fifo_empty=1 -> ps=0, done=1 next cycle.
REQ-039 TIMEOUT=4, eng_done never asserted -> ps=9, err_timeout=1 after 4 WaitComp cycles; start pulse -> Init, err_timeout=0.
REQ-040 fifo_full=1 held 10 cycles in WaitSpace -> no eng_start; release -> eng_start one cycle later.
REQ-041 abort=1 during WaitComp with eng_done=1 same cycle -> ps=0 next cycle, no Write, item_idx unchanged.
REQ-042 rst=1 during WaitRel with read_sw=1 -> ps=0, item_idx=0, rd_req=0 next cycle.

Source files
------------

// File: rtl/wrapper_seq_ctrl.sv
// wrapper_seq_ctrl: job sequencer around an engine and a result FIFO.
// Runs the engine ITEMS times per job (waiting for FIFO space before each
// start), then lets the user drain the FIFO one read per switch press.
// Ports:
//   clk, rst            - clock, synchronous active-high reset
//   start, abort        - job request level, job cancel
//   eng_done            - engine completion
//   fifo_full/empty     - result FIFO status
//   read_sw             - user read switch (already synchronised)
//   eng_start, rd_req   - one-cycle engine start / FIFO read pulses
//   done, busy          - idle-and-ready, job in progress
//   err_timeout         - sticky engine-timeout flag
//   item_idx, ps        - current run index, current state code
module wrapper_seq_ctrl #(
  parameter int unsigned CNT_W   = 4,
  parameter int unsigned ITEMS   = 10,
  parameter int unsigned TO_W    = 8,
  parameter int unsigned TIMEOUT = 200
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic             eng_done,
  input  logic             fifo_full,
  input  logic             fifo_empty,
  input  logic             read_sw,
  output logic             eng_start,
  output logic             rd_req,
  output logic             done,
  output logic             busy,
  output logic             err_timeout,
  output logic [CNT_W-1:0] item_idx,
  output logic [3:0]       ps
);

  localparam logic [CNT_W-1:0] IDX_LAST = CNT_W'(ITEMS - 1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);
  localparam logic [TO_W-1:0]  TO_MAX   = '1;

  typedef enum logic [3:0] {
    S_IDLE       = 4'd0,
    S_INIT       = 4'd1,
    S_WAIT_SPACE = 4'd2,
    S_ISSUE      = 4'd3,
    S_WAIT_COMP  = 4'd4,
    S_WRITE      = 4'd5,
    S_DRAIN      = 4'd6,
    S_READ_REQ   = 4'd7,
    S_WAIT_REL   = 4'd8,
    S_ERROR      = 4'd9
  } state_e;

  state_e           ps_q, ps_d;
  logic [CNT_W-1:0] item_idx_q, item_idx_d;
  logic [TO_W-1:0]  timer_q, timer_d;
  logic             err_timeout_q, err_timeout_d;
  logic             eng_start_q, rd_req_q, done_q, busy_q;

  // Next-state and datapath update
  always_comb begin
    ps_d          = ps_q;
    item_idx_d    = item_idx_q;
    timer_d       = timer_q;
    err_timeout_d = err_timeout_q;
    case (ps_q)
      S_IDLE: if (start) ps_d = S_INIT;
      S_INIT: begin
        item_idx_d    = '0;
        timer_d       = '0;
        err_timeout_d = 1'b0;
        if (!start) ps_d = S_WAIT_SPACE;
      end
      S_WAIT_SPACE: if (!fifo_full) ps_d = S_ISSUE;
      S_ISSUE: begin
        timer_d = '0;
        ps_d    = S_WAIT_COMP;
      end
      S_WAIT_COMP: begin
        // completion wins over a timeout landing in the same cycle
        if (eng_done) begin
          ps_d = S_WRITE;
        end else begin
          if (timer_q != TO_MAX) timer_d = timer_q + TO_W'(1);
          if ((TIMEOUT != 0) && (timer_q == TO_LAST)) begin
            ps_d          = S_ERROR;
            err_timeout_d = 1'b1;
          end
        end
      end
      S_WRITE: begin
        if (item_idx_q == IDX_LAST) begin
          ps_d = S_DRAIN;
        end else begin
          item_idx_d = item_idx_q + CNT_W'(1);
          ps_d       = S_WAIT_SPACE;
        end
      end
      S_DRAIN: begin
        if (fifo_empty)   ps_d = S_IDLE;
        else if (read_sw) ps_d = S_READ_REQ;
      end
      S_READ_REQ: ps_d = S_WAIT_REL;
      S_WAIT_REL: if (!read_sw) ps_d = S_DRAIN;
      S_ERROR:    if (start) ps_d = S_INIT;
      default:    ps_d = S_IDLE;
    endcase
    // abort overrides everything but leaves the counters untouched
    if (abort && (ps_q != S_IDLE)) begin
      ps_d          = S_IDLE;
      item_idx_d    = item_idx_q;
      timer_d       = timer_q;
      err_timeout_d = err_timeout_q;
    end
  end

  // State register; Moore outputs are decoded from the next state so the
  // registered outputs line up with ps.
  always_ff @(posedge clk) begin
    if (rst) begin
      ps_q          <= S_IDLE;
      item_idx_q    <= '0;
      timer_q       <= '0;
      err_timeout_q <= 1'b0;
      eng_start_q   <= 1'b0;
      rd_req_q      <= 1'b0;
      done_q        <= 1'b1;
      busy_q        <= 1'b0;
    end else begin
      ps_q          <= ps_d;
      item_idx_q    <= item_idx_d;
      timer_q       <= timer_d;
      err_timeout_q <= err_timeout_d;
      eng_start_q   <= (ps_d == S_ISSUE);
      rd_req_q      <= (ps_d == S_READ_REQ);
      done_q        <= (ps_d == S_IDLE);
      busy_q        <= (ps_d != S_IDLE) && (ps_d != S_ERROR);
    end
  end

  assign eng_start   = eng_start_q;
  assign rd_req      = rd_req_q;
  assign done        = done_q;
  assign busy        = busy_q;
  assign err_timeout = err_timeout_q;
  assign item_idx    = item_idx_q;
  assign ps          = ps_q;

endmodule

// File: tb/tb_wrapper_seq_ctrl.sv
// Testbench for wrapper_seq_ctrl (ITEMS=3, TIMEOUT=4): vector table plus
// hand-written sequences for FIFO-full stall and reset during WaitRel.
module tb_wrapper_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst, start, abort, eng_done, fifo_full, fifo_empty, read_sw;
  logic       eng_start, rd_req, done, busy, err_timeout;
  logic [3:0] item_idx;
  logic [3:0] ps;

  int checks = 0;
  int errors = 0;

  wrapper_seq_ctrl #(.CNT_W(4), .ITEMS(3), .TO_W(8), .TIMEOUT(4)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .eng_done(eng_done),
    .fifo_full(fifo_full), .fifo_empty(fifo_empty), .read_sw(read_sw),
    .eng_start(eng_start), .rd_req(rd_req), .done(done), .busy(busy),
    .err_timeout(err_timeout), .item_idx(item_idx), .ps(ps)
  );

  always #5 clk = ~clk;

  // in = {rst,start,abort,eng_done,fifo_full,fifo_empty,read_sw}
  // out = {eng_start,rd_req,done,busy,err_timeout}
  typedef struct {
    logic [6:0] in;
    logic [3:0] ps;
    logic [3:0] idx;
    logic [4:0] out;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t v(input logic [6:0] in, input logic [3:0] p,
                             input logic [3:0] i, input logic [4:0] o);
    vec_t r;
    r.in = in; r.ps = p; r.idx = i; r.out = o;
    return r;
  endfunction

  task automatic apply(input logic [6:0] in);
    {rst, start, abort, eng_done, fifo_full, fifo_empty, read_sw} = in;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int n, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d] got %0h expected %0h", name, n, act, exp);
    end
  endtask

  localparam logic [4:0] O_IDLE = 5'b00100, O_BUSY = 5'b00010,
                         O_ISS  = 5'b10010, O_RD   = 5'b01010,
                         O_ERR  = 5'b00001;

  initial begin
    int starts;
    {rst, start, abort, eng_done, fifo_full, fifo_empty, read_sw} = 7'b1000000;

    // reset, job start, three engine runs
    tbl.push_back(v(7'b1000000, 0, 0, O_IDLE));
    tbl.push_back(v(7'b0000000, 0, 0, O_IDLE));
    tbl.push_back(v(7'b0100000, 1, 0, O_BUSY));
    tbl.push_back(v(7'b0100000, 1, 0, O_BUSY));
    tbl.push_back(v(7'b0000000, 2, 0, O_BUSY));
    for (int i = 0; i < 3; i++) begin
      if (i != 0) tbl.push_back(v(7'b0000000, 2, 4'(i), O_BUSY));
      if (i == 0) begin end
      tbl.push_back(v(7'b0000000, 3, 4'(i), O_ISS));
      tbl.push_back(v(7'b0000000, 4, 4'(i), O_BUSY));
      tbl.push_back(v(7'b0001000, 5, 4'(i), O_BUSY));
    end
    tbl.push_back(v(7'b0000000, 6, 2, O_BUSY));
    // drain: two presses of 5 cycles each, then empty wins over read_sw
    for (int p = 0; p < 2; p++) begin
      tbl.push_back(v(7'b0000001, 7, 2, O_RD));
      for (int k = 0; k < 4; k++) tbl.push_back(v(7'b0000001, 8, 2, O_BUSY));
      tbl.push_back(v(7'b0000000, 6, 2, O_BUSY));
      tbl.push_back(v(7'b0000000, 6, 2, O_BUSY));
    end
    tbl.push_back(v(7'b0000011, 0, 2, O_IDLE));
    // timeout: 4 WaitComp cycles then Error; start recovers and clears flag
    tbl.push_back(v(7'b0100000, 1, 2, O_BUSY));
    tbl.push_back(v(7'b0000000, 2, 0, O_BUSY));
    tbl.push_back(v(7'b0000000, 3, 0, O_ISS));
    tbl.push_back(v(7'b0000000, 4, 0, O_BUSY));
    tbl.push_back(v(7'b0000000, 4, 0, O_BUSY));
    tbl.push_back(v(7'b0000000, 4, 0, O_BUSY));
    tbl.push_back(v(7'b0000000, 4, 0, O_BUSY));
    tbl.push_back(v(7'b0000000, 9, 0, O_ERR));
    tbl.push_back(v(7'b0000000, 9, 0, O_ERR));
    tbl.push_back(v(7'b0001000, 9, 0, O_ERR));
    tbl.push_back(v(7'b0100000, 1, 0, 5'b00011));
    tbl.push_back(v(7'b0000000, 2, 0, O_BUSY));
    // abort with eng_done in WaitComp of the second run
    tbl.push_back(v(7'b0000000, 3, 0, O_ISS));
    tbl.push_back(v(7'b0000000, 4, 0, O_BUSY));
    tbl.push_back(v(7'b0001000, 5, 0, O_BUSY));
    tbl.push_back(v(7'b0000000, 2, 1, O_BUSY));
    tbl.push_back(v(7'b0000000, 3, 1, O_ISS));
    tbl.push_back(v(7'b0000000, 4, 1, O_BUSY));
    tbl.push_back(v(7'b0011000, 0, 1, O_IDLE));
    tbl.push_back(v(7'b0000000, 0, 1, O_IDLE));
    tbl.push_back(v(7'b0010000, 0, 1, O_IDLE));

    foreach (tbl[n]) begin
      apply(tbl[n].in);
      chk("ps", n, 32'(ps), 32'(tbl[n].ps));
      chk("item_idx", n, 32'(item_idx), 32'(tbl[n].idx));
      chk("outs", n, 32'({eng_start, rd_req, done, busy, err_timeout}),
          32'(tbl[n].out));
    end

    // FIFO full holds off the engine for 10 cycles
    apply(7'b0100000); chk("seq_init", 0, 32'(ps), 1);
    apply(7'b0000000); chk("seq_ws", 0, 32'(ps), 2);
    for (int c = 0; c < 10; c++) begin
      apply(7'b0000100);
      chk("full_ps", c, 32'(ps), 2);
      chk("full_es", c, 32'(eng_start), 0);
    end
    apply(7'b0000000);
    chk("rel_ps", 0, 32'(ps), 3);
    chk("rel_es", 0, 32'(eng_start), 1);
    starts = 1;
    // responsive engine until Drain, bounded
    for (int c = 0; c < 40 && ps != 4'd6; c++) begin
      apply({3'b000, (ps == 4'd4), 3'b000});
      if (eng_start) starts++;
    end
    chk("run_ps", 0, 32'(ps), 6);
    chk("run_starts", 0, 32'(starts), 3);
    chk("run_idx", 0, 32'(item_idx), 2);
    // reset while waiting for switch release
    apply(7'b0000001); chk("rr_ps", 0, 32'(ps), 7); chk("rr_rd", 0, 32'(rd_req), 1);
    apply(7'b0000001); chk("wr_ps", 0, 32'(ps), 8); chk("wr_rd", 0, 32'(rd_req), 0);
    apply(7'b1000001);
    chk("rst_ps", 0, 32'(ps), 0);
    chk("rst_idx", 0, 32'(item_idx), 0);
    chk("rst_outs", 0, 32'({eng_start, rd_req, done, busy, err_timeout}), 32'(O_IDLE));
    apply(7'b0000001);
    chk("post_ps", 0, 32'(ps), 0);
    chk("post_rd", 0, 32'(rd_req), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
